// File: rtl/alu_issue_ctrl.sv
// Issue sequencer between decode and the alu: holds a decoded op at the alu inputs
// for its class latency, then presents the alu result to writeback with backpressure.
module alu_issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_opcode,
  input  logic [11:0] in_regB,
  input  logic [4:0]  in_regDest,
  input  logic [19:0] in_uimm,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic [63:0] in_regA_value,
  input  logic [63:0] in_regB_value,
  output logic [9:0]  alu_opcode,
  output logic [11:0] alu_regB,
  output logic [4:0]  alu_regDest,
  output logic [19:0] alu_uimm,
  output logic [31:0] alu_pc,
  output logic [31:0] alu_inst,
  output logic [63:0] alu_regA_value,
  output logic [63:0] alu_regB_value,
  input  logic [63:0] alu_data_out,
  input  logic [63:0] alu_mem_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_data,
  output logic [63:0] wb_mem_addr,
  output logic [4:0]  wb_rd,
  output logic        wb_is_store,
  output logic        busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_wb_rd;
  logic             r_wb_is_store;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_init;

  // M-extension ops (funct7=1) get the long latencies; funct3[2] splits mul from div/rem.
  function automatic logic [CNT_W-1:0] f_cnt_init(input logic [9:0] opc, input logic [6:0] f7);
    logic m_op;
    m_op = ((opc[6:0] == 7'h33) || (opc[6:0] == 7'h3b)) && (f7 == 7'd1);
    if (!m_op)       return '0;
    else if (opc[9]) return CNT_W'(DIV_LAT - 1);
    else             return CNT_W'(MUL_LAT - 1);
  endfunction

  assign w_cnt_init  = f_cnt_init(in_opcode, in_regB[11:5]);
  assign in_ready    = !reset && !flush &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && wb_ready));
  assign w_accept    = in_valid && in_ready;
  assign wb_valid    = (r_state == S_RESP) && !flush;
  assign wb_data     = wb_valid ? alu_data_out : '0;
  assign wb_mem_addr = wb_valid ? alu_mem_out : '0;
  assign wb_rd       = r_wb_rd;
  assign wb_is_store = r_wb_is_store;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_EXEC;
          r_cnt   <= w_cnt_init;
        end
        S_EXEC: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                else             r_state <= S_RESP;
        S_RESP: if (wb_ready) begin
          if (in_valid) begin
            r_state <= S_EXEC;
            r_cnt   <= w_cnt_init;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operands stay frozen at the alu inputs until the next accept; flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_opcode     <= '0;
      alu_regB       <= '0;
      alu_regDest    <= '0;
      alu_uimm       <= '0;
      alu_pc         <= '0;
      alu_inst       <= '0;
      alu_regA_value <= '0;
      alu_regB_value <= '0;
      r_wb_rd        <= '0;
      r_wb_is_store  <= 1'b0;
    end else if (w_accept) begin
      alu_opcode     <= in_opcode;
      alu_regB       <= in_regB;
      alu_regDest    <= in_regDest;
      alu_uimm       <= in_uimm;
      alu_pc         <= in_pc;
      alu_inst       <= in_inst;
      alu_regA_value <= in_regA_value;
      alu_regB_value <= in_regB_value;
      r_wb_rd        <= ((in_opcode[6:0] == 7'h23) || (in_opcode[6:0] == 7'h63)) ? 5'd0 : in_regDest;
      r_wb_is_store  <= (in_opcode[6:0] == 7'h23);
    end
  end

endmodule
